digit_field_ctrl: RTL and testbench

//  Scheduler for the shared 16-glyph digit ROM on the 256x240 composite raster.

---
 rtl/digit_field_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_digit_field_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_field_ctrl.sv
// Four 4-hex-digit on-screen fields rendered through a shared glyph ROM, with shadow->live
// commit during vsync. Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module digit_field_ctrl #(
    parameter int X0        = 16,
    parameter int Y0        = 8,
    parameter int ROW_PITCH = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        display_on,
    input  logic        vsync,
    input  logic        upd_valid,
    input  logic [1:0]  upd_field,
    input  logic [15:0] upd_value,
    output logic        upd_ready,
    output logic [3:0]  rom_digit,
    output logic [2:0]  rom_yoff,
    input  logic [4:0]  rom_bits,
    output logic        pixel_on,
    output logic        committing
);

    typedef enum logic {RUN, COMMIT} state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic        vsync_q;
    logic        upd_ready_q;
    logic        committing_q;
    logic [3:0]  dirty_q;
    logic [3:0]  dirty_d;
    logic [15:0] shadow_q [4];
    logic [15:0] live_q   [4];
    logic        wr_en;

    logic signed [11:0] dx_s0;
    logic signed [11:0] dy_s0;
    logic               hit_s0;
    logic [1:0]         fld_s0;
    logic [2:0]         yoff_s0;
    logic               blank_s0;

    logic       in_field_p1_q;
    logic [1:0] field_p1_q;
    logic [1:0] digit_p1_q;
    logic [2:0] xoff_p1_q;
    logic [2:0] yoff_p1_q;
    logic       disp_p1_q;
    logic       blank_p1_q;
    logic [7:0] bits_p1;
    logic       pixel_on_p2_q;

    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd0:    nibble_sel = v[15:12];
            2'd1:    nibble_sel = v[11:8];
            2'd2:    nibble_sel = v[7:4];
            default: nibble_sel = v[3:0];
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // The rightmost digit is never blanked, so a zero value still shows "0".
    function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd0:    lead_zero = (v[15:12] == 4'h0);
            2'd1:    lead_zero = (v[15:8] == 8'h00);
            2'd2:    lead_zero = (v[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    endfunction
`endif

    // S0: locate the beam relative to the four fields
    always_comb begin
        dx_s0   = $signed({3'b000, hpos}) - 12'(X0);
        dy_s0   = '0;
        hit_s0  = 1'b0;
        fld_s0  = '0;
        yoff_s0 = '0;
        for (int f = 0; f < 4; f++) begin
            dy_s0 = $signed({3'b000, vpos}) - 12'(Y0 + f * ROW_PITCH);
            if (!hit_s0 && dx_s0 >= 12'sd0 && dx_s0 < 12'sd64 &&
                dy_s0 >= 12'sd0 && dy_s0 < 12'sd16) begin
                hit_s0  = 1'b1;
                fld_s0  = 2'(f);
                yoff_s0 = dy_s0[3:1];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_s0 = hit_s0 && lead_zero(live_q[fld_s0], dx_s0[5:4]);
`else
    assign blank_s0 = 1'b0;
`endif

    // S1: registered beam decode; ROM address is driven from here
    always_ff @(posedge clk) begin
        if (reset) begin
            in_field_p1_q <= 1'b0;
            field_p1_q    <= '0;
            digit_p1_q    <= '0;
            xoff_p1_q     <= '0;
            yoff_p1_q     <= '0;
            disp_p1_q     <= 1'b0;
            blank_p1_q    <= 1'b0;
        end else begin
            in_field_p1_q <= hit_s0;
            field_p1_q    <= fld_s0;
            digit_p1_q    <= hit_s0 ? dx_s0[5:4] : 2'd0;
            xoff_p1_q     <= dx_s0[3:1];
            yoff_p1_q     <= yoff_s0;
            disp_p1_q     <= display_on;
            blank_p1_q    <= blank_s0;
        end
    end

    assign rom_digit = in_field_p1_q ? nibble_sel(live_q[field_p1_q], digit_p1_q) : 4'h0;
    assign rom_yoff  = yoff_p1_q;
    assign bits_p1   = {3'b000, rom_bits};

    // S2: glyph bit select, 5x5 glyph cell
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on_p2_q <= 1'b0;
        end else begin
            pixel_on_p2_q <= disp_p1_q && in_field_p1_q && (xoff_p1_q < 3'd5) &&
                             (yoff_p1_q < 3'd5) && bits_p1[xoff_p1_q] && !blank_p1_q;
        end
    end

    assign pixel_on = pixel_on_p2_q;

    assign wr_en   = upd_valid && upd_ready_q;
    assign dirty_d = dirty_q | (wr_en ? (4'b0001 << upd_field) : 4'b0000);

    // Update acceptance and vsync commit; a write on the edge cycle joins this commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            idx_q        <= '0;
            vsync_q      <= 1'b0;
            upd_ready_q  <= 1'b1;
            committing_q <= 1'b0;
            dirty_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            vsync_q <= vsync;
            if (wr_en) begin
                shadow_q[upd_field] <= upd_value;
            end
            case (state_q)
                RUN: begin
                    dirty_q <= dirty_d;
                    if (vsync && !vsync_q && (dirty_d != 4'b0000)) begin
                        state_q      <= COMMIT;
                        idx_q        <= '0;
                        upd_ready_q  <= 1'b0;
                        committing_q <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (dirty_q[idx_q]) begin
                        live_q[idx_q]  <= shadow_q[idx_q];
                        dirty_q[idx_q] <= 1'b0;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q      <= RUN;
                        upd_ready_q  <= 1'b1;
                        committing_q <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign upd_ready  = upd_ready_q;
    assign committing = committing_q;

endmodule

// File: tb/tb_digit_field_ctrl.sv
// Randomized bench for digit_field_ctrl: beam positions and updates checked against a
// field/digit reference model and a bench-side glyph ROM.
module tb_digit_field_ctrl;

    localparam int X0    = 16;
    localparam int Y0    = 8;
    localparam int PITCH = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        vsync;
    logic        upd_valid;
    logic [1:0]  upd_field;
    logic [15:0] upd_value;
    logic        upd_ready;
    logic [3:0]  rom_digit;
    logic [2:0]  rom_yoff;
    logic [4:0]  rom_bits;
    logic        pixel_on;
    logic        committing;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] shadow_m [4];
    logic [15:0] live_m   [4];
    bit          pend_m   [4];
    bit          exp_q    [$];

    always #5 clk = ~clk;

    function automatic logic [4:0] font(input logic [3:0] g, input logic [2:0] y);
        logic [7:0] t;
        t = 8'(g) * 8'd29 + 8'(y) * 8'd53 + 8'd17;
        return t[6:2] ^ {y[1:0], g[2:0]};
    endfunction

    assign rom_bits = font(rom_digit, rom_yoff);

    digit_field_ctrl #(.X0(X0), .Y0(Y0), .ROW_PITCH(PITCH)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .vsync(vsync), .upd_valid(upd_valid), .upd_field(upd_field), .upd_value(upd_value),
        .upd_ready(upd_ready), .rom_digit(rom_digit), .rom_yoff(rom_yoff),
        .rom_bits(rom_bits), .pixel_on(pixel_on), .committing(committing)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int fld_of(input int h, input int v);
        for (int f = 0; f < 4; f++)
            if (v >= Y0 + f * PITCH && v < Y0 + f * PITCH + 16 && h >= X0 && h < X0 + 64)
                return f;
        return -1;
    endfunction

    function automatic logic [3:0] model_dig(input int h, input int v);
        int f = fld_of(h, v);
        if (f < 0) return 4'h0;
        return 4'((live_m[f] >> (12 - 4 * ((h - X0) / 16))) & 16'h000f);
    endfunction

    function automatic logic [2:0] model_yo(input int h, input int v);
        int f = fld_of(h, v);
        if (f < 0) return 3'd0;
        return 3'(((v - Y0 - f * PITCH) % 16) / 2);
    endfunction

    function automatic bit model_pix(input int h, input int v, input bit disp);
        int f = fld_of(h, v);
        int d;
        int xo;
        int yo;
        logic [4:0] fb;
        if (f < 0 || !disp) return 1'b0;
        d  = (h - X0) / 16;
        xo = ((h - X0) % 16) / 2;
        yo = ((v - Y0 - f * PITCH) % 16) / 2;
        if (xo >= 5 || yo >= 5) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d < 3 && (live_m[f] >> (12 - 4 * d)) == 16'h0) return 1'b0;
`endif
        fb = font(model_dig(h, v), 3'(yo));
        return fb[xo];
    endfunction

    function automatic logic [15:0] rnd_val();
        int k = int'($urandom_range(0, 4));
        return 16'($urandom) & (16'hffff >> (4 * k));
    endfunction

    function automatic bit pend_any();
        return pend_m[0] || pend_m[1] || pend_m[2] || pend_m[3];
    endfunction

    task automatic pix(input int h, input int v, input bit disp, input bit wr);
        logic [3:0] ed;
        logic [2:0] ey;
        logic [1:0] f;
        logic [15:0] val;
        hpos       = 9'(h);
        vpos       = 9'(v);
        display_on = disp;
        upd_valid  = 1'b0;
        if (wr && $urandom_range(0, 15) == 0) begin
            f   = 2'($urandom);
            val = rnd_val();
            chk("ready_run", upd_ready, 1);
            upd_valid = 1'b1;
            upd_field = f;
            upd_value = val;
            shadow_m[f] = val;
            pend_m[f]   = 1'b1;
        end
        exp_q.push_back(model_pix(h, v, disp));
        ed = model_dig(h, v);
        ey = model_yo(h, v);
        cyc();
        chk("rom_digit", rom_digit, ed);
        chk("rom_yoff", rom_yoff, ey);
        if (exp_q.size() == 2) chk("pixel_on", pixel_on, exp_q.pop_front());
    endtask

    task automatic frame(input bit wr);
        exp_q.delete();
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 16; r += 6)
                for (int h = X0 - 4; h < X0 + 68; h++)
                    pix(h, Y0 + f * PITCH + r, 1'b1, wr);
        for (int n = 0; n < 500; n++)
            pix(int'($urandom_range(0, 100)), int'($urandom_range(0, 110)),
                $urandom_range(0, 7) != 0, wr);
        for (int n = 0; n < 40; n++)
            pix(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'b1, wr);
        upd_valid = 1'b0;
    endtask

    task automatic wr_cycle(input logic [1:0] f, input logic [15:0] v);
        chk("ready_idle", upd_ready, 1);
        upd_valid = 1'b1;
        upd_field = f;
        upd_value = v;
        shadow_m[f] = v;
        pend_m[f]   = 1'b1;
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic do_vsync(input bit wr, input logic [1:0] wf, input logic [15:0] wv,
                            input bit hold, input bit rst_mid);
        bit          exp_c;
        logic [1:0]  hf;
        logic [15:0] hv;
        display_on = 1'b0;
        hpos       = 9'd300;
        vpos       = 9'd250;
        vsync      = 1'b0;
        upd_valid  = 1'b0;
        cyc();
        cyc();
        vsync = 1'b1;
        if (wr) begin
            upd_valid = 1'b1;
            upd_field = wf;
            upd_value = wv;
            shadow_m[wf] = wv;
            pend_m[wf]   = 1'b1;
        end
        exp_c = pend_any();
        cyc();
        upd_valid = 1'b0;
        if (exp_c) begin
            for (int f = 0; f < 4; f++) begin
                if (pend_m[f]) live_m[f] = shadow_m[f];
                pend_m[f] = 1'b0;
            end
        end
        hf = 2'($urandom);
        hv = rnd_val() | 16'h8000;
        if (hold && exp_c) begin
            upd_valid = 1'b1;
            upd_field = hf;
            upd_value = hv;
        end
        for (int i = 0; i < 4; i++) begin
            chk("committing", committing, exp_c);
            chk("ready_commit", upd_ready, !exp_c);
            if (rst_mid && i == 2) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
                for (int f = 0; f < 4; f++) begin
                    live_m[f]   = '0;
                    shadow_m[f] = '0;
                    pend_m[f]   = 1'b0;
                end
                chk("rst_committing", committing, 0);
                chk("rst_ready", upd_ready, 1);
                chk("rst_pixel", pixel_on, 0);
                chk("rst_digit", rom_digit, 0);
                vsync = 1'b0;
                cyc();
                return;
            end
            cyc();
        end
        chk("commit_done", committing, 0);
        chk("ready_after", upd_ready, 1);
        if (hold && exp_c) begin
            cyc();
            shadow_m[hf] = hv;
            pend_m[hf]   = 1'b1;
            upd_valid    = 1'b0;
        end
        vsync = 1'b0;
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        hpos       = '0;
        vpos       = '0;
        display_on = 1'b0;
        vsync      = 1'b0;
        upd_valid  = 1'b0;
        upd_field  = '0;
        upd_value  = '0;
        for (int f = 0; f < 4; f++) begin
            shadow_m[f] = '0;
            live_m[f]   = '0;
            pend_m[f]   = 1'b0;
        end
        cyc();
        cyc();
        chk("reset_pixel", pixel_on, 0);
        chk("reset_digit", rom_digit, 0);
        chk("reset_yoff", rom_yoff, 0);
        chk("reset_committing", committing, 0);
        chk("reset_ready", upd_ready, 1);
        reset = 1'b0;

        frame(1'b0);
        frame(1'b1);
        wr_cycle(2'd1, 16'h1234);
        frame(1'b0);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        frame(1'b0);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        frame(1'b0);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        do_vsync(1'b1, 2'd2, 16'hbe7f, 1'b0, 1'b0);
        frame(1'b0);
        wr_cycle(2'd3, 16'haaaa);
        wr_cycle(2'd3, 16'h5555);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        frame(1'b0);
        wr_cycle(2'd0, 16'h0105);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        frame(1'b0);
        wr_cycle(2'd2, 16'h4321);
        wr_cycle(2'd1, 16'h0f0f);
        do_vsync(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        frame(1'b0);
        for (int k = 0; k < 3; k++) begin
            frame(1'b1);
            do_vsync($urandom_range(0, 1) == 1, 2'($urandom), rnd_val(),
                     $urandom_range(0, 1) == 1, 1'b0);
        end
        frame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
